// File: rtl/adc_dac_bridge.sv
// N-channel ADC-to-DAC sample bridge: format select, saturating gain, test sources,
// output freeze and sticky overflow, in a fixed 3-cycle-latency pipeline.
`timescale 1ns/1ps
module adc_dac_bridge #(
  parameter int NCH       = 2,
  parameter int ADC_W     = 12,
  parameter int DAC_W     = 14,
  parameter int RAMP_STEP = 4
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic [NCH*ADC_W-1:0]   adc_data,
  input  logic                   adc_valid,
  input  logic                   fmt_signed,
  input  logic [1:0]             mode,
  input  logic [1:0]             shift,
  input  logic [DAC_W-1:0]       const_val,
  input  logic                   freeze,
  input  logic                   clr_ovf,
  output logic [NCH*DAC_W-1:0]   dac_data,
  output logic                   dac_valid,
  output logic [NCH-1:0]         ovf,
  output logic [NCH*ADC_W-1:0]   debug_adc
);

  localparam int GW = DAC_W + 3;
  localparam logic [DAC_W-1:0] MID     = DAC_W'(1) << (DAC_W - 1);
  localparam logic [DAC_W-1:0] STEP    = DAC_W'(RAMP_STEP);
  localparam logic [ADC_W-1:0] ADC_MSB = ADC_W'(1) << (ADC_W - 1);

  // Handshake: valid-only, no backpressure. A sample is taken on every edge with
  // adc_valid=1; dac_valid pulses for one cycle per emitted sample, 3 edges later.

  logic             v1, fmt1;
  logic [1:0]       mode1, shift1;
  logic [DAC_W-1:0] const1, ramp1, ramp_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      fmt1      <= 1'b0;
      mode1     <= 2'd0;
      shift1    <= 2'd0;
      const1    <= '0;
      ramp1     <= '0;
      ramp_cnt  <= '0;
      debug_adc <= '0;
    end else begin
      v1 <= adc_valid;
      if (adc_valid) begin
        debug_adc <= adc_data;
        fmt1      <= fmt_signed;
        mode1     <= mode;
        shift1    <= shift;
        const1    <= const_val;
        ramp1     <= ramp_cnt;
        if (mode == 2'd1) ramp_cnt <= ramp_cnt + STEP;
      end
    end
  end

  logic             v2;
  logic [1:0]       mode2, shift2;
  logic [DAC_W-1:0] const2, ramp2;
  logic [DAC_W-1:0] a2_n [NCH];
  logic [DAC_W-1:0] a2   [NCH];

  // Offset binary becomes two's complement by flipping the MSB, then left-align.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      a2_n[k] = DAC_W'(debug_adc[k*ADC_W +: ADC_W] ^ (fmt1 ? '0 : ADC_MSB)) << (DAC_W - ADC_W);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      mode2  <= 2'd0;
      shift2 <= 2'd0;
      const2 <= '0;
      ramp2  <= '0;
      for (int k = 0; k < NCH; k++) a2[k] <= '0;
    end else begin
      v2     <= v1;
      mode2  <= mode1;
      shift2 <= shift1;
      const2 <= const1;
      ramp2  <= ramp1;
      for (int k = 0; k < NCH; k++) a2[k] <= a2_n[k];
    end
  end

  logic [GW-1:0]    g3   [NCH];
  logic [DAC_W-1:0] r3_n [NCH];
  logic [DAC_W-1:0] r3   [NCH];
  logic [NCH-1:0]   sat3_n, sat3;
  logic             v3;

  // The gained value fits only if all bits from the DAC sign bit upward agree.
  always_comb begin
    sat3_n = '0;
    for (int k = 0; k < NCH; k++) begin
      g3[k]   = {{3{a2[k][DAC_W-1]}}, a2[k]} << shift2;
      r3_n[k] = {~g3[k][DAC_W-1], g3[k][DAC_W-2:0]};
      if (!(&g3[k][GW-1:DAC_W-1]) && (|g3[k][GW-1:DAC_W-1])) begin
        sat3_n[k] = 1'b1;
        r3_n[k]   = g3[k][GW-1] ? '0 : '1;
      end
      case (mode2)
        2'd1:    begin r3_n[k] = ramp2;  sat3_n[k] = 1'b0; end
        2'd2:    begin r3_n[k] = const2; sat3_n[k] = 1'b0; end
        2'd3:    begin r3_n[k] = MID;    sat3_n[k] = 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      sat3 <= '0;
      for (int k = 0; k < NCH; k++) r3[k] <= '0;
    end else begin
      v3   <= v2;
      sat3 <= sat3_n;
      for (int k = 0; k < NCH; k++) r3[k] <= r3_n[k];
    end
  end

  // Saturation is recorded even while frozen; a set in the same cycle beats clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_valid <= 1'b0;
      ovf       <= '0;
      dac_data  <= {NCH{MID}};
    end else begin
      dac_valid <= v3 & ~freeze;
      ovf       <= (clr_ovf ? '0 : ovf) | (v3 ? sat3 : '0);
      if (v3 && !freeze) begin
        for (int k = 0; k < NCH; k++) dac_data[k*DAC_W +: DAC_W] <= r3[k];
      end
    end
  end

endmodule
